// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed common-anode 7-segment driver with snapshot, LZ blanking and dead time
module seg7_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int HEX_MODE    = 0,
    parameter int LZ_BLANK    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    update,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [(NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1)-1:0] scan_idx
);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = $clog2(REFRESH_DIV);

    logic [4*NUM_DIGITS-1:0] digits_q;
    logic [NUM_DIGITS-1:0]   dp_q, blank_q, an_q, an_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d, sidx_q, sidx_d;
    logic [6:0]              seg_q, seg_d, glyph;
    logic                    dpo_q, dpo_d, tick, dark, zero_above, lz, blk, dpr;
    logic [3:0]              nib;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'h0: decode = 7'b0000001;
            4'h1: decode = 7'b1001111;
            4'h2: decode = 7'b0010010;
            4'h3: decode = 7'b0000110;
            4'h4: decode = 7'b1001100;
            4'h5: decode = 7'b0100100;
            4'h6: decode = 7'b0100000;
            4'h7: decode = 7'b0001111;
            4'h8: decode = 7'b0000000;
            4'h9: decode = 7'b0000100;
            4'hA: decode = HEX_MODE != 0 ? 7'b0001000 : 7'h7F;
            4'hB: decode = HEX_MODE != 0 ? 7'b1100000 : 7'h7F;
            4'hC: decode = HEX_MODE != 0 ? 7'b0110001 : 7'h7F;
            4'hD: decode = HEX_MODE != 0 ? 7'b1000010 : 7'h7F;
            4'hE: decode = HEX_MODE != 0 ? 7'b0110000 : 7'h7F;
            default: decode = HEX_MODE != 0 ? 7'b0111000 : 7'h7F;
        endcase
    endfunction

    always_comb begin
        tick  = cnt_q == CW'(REFRESH_DIV - 1);
        cnt_d = !enable || tick ? '0 : cnt_q + CW'(1);
        idx_d = !enable ? '0 : !tick ? idx_q : idx_q == IW'(NUM_DIGITS - 1) ? '0 : idx_q + IW'(1);
        nib = '0;
        dpr = 1'b0;
        blk = 1'b0;
        lz = 1'b0;
        zero_above = 1'b1;
        // walk from the most significant digit so zero_above covers this digit and all higher ones
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && digits_q[4*i +: 4] == 4'd0;
            if (idx_q == IW'(i)) begin
                nib = digits_q[4*i +: 4];
                dpr = dp_q[i];
                blk = blank_q[i];
                lz  = zero_above && i != 0;
            end
        end
        glyph  = decode(nib);
        dark   = !enable || cnt_q == '0;
        seg_d  = dark || blk || (LZ_BLANK != 0 && lz) ? 7'h7F : glyph;
        dpo_d  = dark || blk || !dpr;
        an_d   = dark ? '1 : ~(NUM_DIGITS'(1) << idx_q);
        sidx_d = enable ? idx_q : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digits_q <= '0;
            dp_q     <= '0;
            blank_q  <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            seg_q    <= 7'h7F;
            dpo_q    <= 1'b1;
            an_q     <= '1;
            sidx_q   <= '0;
        end else begin
            if (update) begin
                digits_q <= digits_in;
                dp_q     <= dp_in;
                blank_q  <= blank_in;
            end
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            seg_q  <= seg_d;
            dpo_q  <= dpo_d;
            an_q   <= an_d;
            sidx_q <= sidx_d;
        end
    end

    assign seg      = seg_q;
    assign dp       = dpo_q;
    assign an       = an_q;
    assign scan_idx = sidx_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed plus random stimulus against a slot-arithmetic reference model
module tb_seg7_scan_driver;
    localparam int N = 4;
    localparam int R = 4;

    logic clk = 1'b0;
    logic rst = 1'b1, enable = 1'b0, update = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0, blank_in = '0;
    logic [6:0]  seg, seg_h;
    logic        dp, dp_h;
    logic [3:0]  an, an_h;
    logic [1:0]  scan_idx, scan_idx_h;

    int vecs = 0, errs = 0;
    int t = 0;
    logic [15:0] snap = '0;
    logic [3:0]  sdp = '0, sbl = '0;

    logic [6:0] tbl [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                             7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                             7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(R), .HEX_MODE(0), .LZ_BLANK(1)) dut (
        .clk(clk), .rst(rst), .enable(enable), .update(update), .digits_in(digits_in),
        .dp_in(dp_in), .blank_in(blank_in), .seg(seg), .dp(dp), .an(an), .scan_idx(scan_idx));

    seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(R), .HEX_MODE(1), .LZ_BLANK(1)) dut_hex (
        .clk(clk), .rst(rst), .enable(enable), .update(update), .digits_in(digits_in),
        .dp_in(dp_in), .blank_in(blank_in), .seg(seg_h), .dp(dp_h), .an(an_h), .scan_idx(scan_idx_h));

    always #5 clk = ~clk;

    // t counts cycles since scanning started; slot position and digit follow by division
    task automatic expect_out(output logic [6:0] es, output logic [6:0] eh, output logic edp,
                              output logic [3:0] ean, output logic [1:0] esi);
        int idx, cnt;
        logic [3:0] nib;
        logic blk;
        es = 7'h7F; eh = 7'h7F; edp = 1'b1; ean = 4'hF; esi = 2'd0;
        if (!rst && enable) begin
            cnt = t % R;
            idx = (t / R) % N;
            esi = idx[1:0];
            if (cnt != 0) begin
                ean = ~(4'b1 << idx);
                nib = 4'((snap >> (4*idx)) & 16'hF);
                blk = sbl[idx] || (idx > 0 && (snap >> (4*idx)) == 16'd0);
                es  = blk || nib > 4'd9 ? 7'h7F : tbl[nib];
                eh  = blk ? 7'h7F : tbl[nib];
                edp = sbl[idx] || !sdp[idx];
            end
        end
    endtask

    task automatic cycle();
        logic [6:0] es, eh;
        logic edp;
        logic [3:0] ean;
        logic [1:0] esi;
        expect_out(es, eh, edp, ean, esi);
        @(posedge clk);
        if (rst) begin
            snap = '0; sdp = '0; sbl = '0; t = 0;
        end else begin
            if (update) begin
                snap = digits_in; sdp = dp_in; sbl = blank_in;
            end
            t = enable ? t + 1 : 0;
        end
        #1;
        vecs += 5;
        assert (seg === es) else begin errs++; $error("FAIL seg got %b exp %b at t=%0d", seg, es, t); end
        assert (seg_h === eh) else begin errs++; $error("FAIL seg_hex got %b exp %b at t=%0d", seg_h, eh, t); end
        assert (dp === edp) else begin errs++; $error("FAIL dp got %b exp %b at t=%0d", dp, edp, t); end
        assert (an === ean) else begin errs++; $error("FAIL an got %b exp %b at t=%0d", an, ean, t); end
        assert (scan_idx === esi) else begin errs++; $error("FAIL scan_idx got %0d exp %0d at t=%0d", scan_idx, esi, t); end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
        digits_in = d; dp_in = p; blank_in = b; update = 1'b1;
        cycle();
        update = 1'b0;
    endtask

    initial begin
        run(3);
        rst = 1'b0; enable = 1'b1;
        run(18);
        load(16'h1205, 4'b0100, 4'b0000);
        run(17);
        digits_in = 16'hFFFF; dp_in = 4'b1111; blank_in = 4'b1111;
        run(10);
        load(16'h00A3, 4'b0000, 4'b0000);
        run(17);
        load(16'h0007, 4'b0001, 4'b0001);
        run(17);
        load(16'h4321, 4'b1010, 4'b0000);
        for (int i = 0; i < 40 && !((t / R) % N == 2 && t % R == 2); i++) cycle();
        enable = 1'b0;
        run(3);
        enable = 1'b1;
        run(10);
        digits_in = 16'h1234; dp_in = 4'b1111; update = 1'b1; rst = 1'b1;
        cycle();
        rst = 1'b0; update = 1'b0;
        run(10);
        for (int i = 0; i < 500; i++) begin
            update = $urandom_range(0, 7) == 0;
            if (update) begin
                digits_in = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 3)));
                dp_in = 4'($urandom);
                blank_in = $urandom_range(0, 3) == 0 ? 4'($urandom) : 4'b0000;
            end
            enable = $urandom_range(0, 29) != 0;
            rst = $urandom_range(0, 199) == 0;
            cycle();
        end
        rst = 1'b0; update = 1'b0; enable = 1'b1;
        run(4);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Parametrised, time-multiplexed driver for common-anode 7-segment displays, successor to the single-digit combinational decoder.
- Holds a snapshot of NUM_DIGITS BCD or hex nibbles and scans one digit at a time with a programmable refresh period.
- Drives active-low segments and anodes, with per-digit decimal point, per-digit blanking, leading-zero blanking and anti-ghosting dead time.
- Sits between the clock/timekeeping counters and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned; must be >= 1.
- REFRESH_DIV, 100000, clk cycles per digit slot; must be >= 2.
- HEX_MODE, 0, 0 = codes 10-15 render blank; 1 = codes 10-15 render A,b,C,d,E,F.
- LZ_BLANK, 1, 1 = leading-zero blanking enabled; 0 = disabled.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  1 = scanning; 0 = display dark, scan counters held at 0.
- update  in  1  one-cycle strobe that loads digits_in, dp_in and blank_in into the snapshot.
- digits_in  in  4*NUM_DIGITS  nibble i is at [4i+3:4i]; digit 0 is least significant and rightmost.
- dp_in  in  NUM_DIGITS  decimal point request per digit; 1 = lit.
- blank_in  in  NUM_DIGITS  1 = force digit i dark, including its decimal point.
- seg  out  7  {a,b,c,d,e,f,g}, active-low.
- dp  out  1  decimal point segment, active-low.
- an  out  NUM_DIGITS  anode selects, active-low, at most one bit low at any time.
- scan_idx  out  clog2(NUM_DIGITS), min 1  index of the digit currently driven.

Behaviour:
- Reset: the following are all cleared.
  - Snapshot (digits, dp, blank) = 0.
  - Prescaler cnt = 0.
  - idx = 0.
  - seg = 7'b1111111, dp = 1, an = all 1s, scan_idx = 0.
- Snapshot:
  - Loads only on a cycle with update=1. Between strobes, changes on the inputs have no effect, so there is no tearing.
  - When update and a slot tick fall in the same cycle, the snapshot loads and the next slot uses the new data.
- Prescaler, while enable=1:
  - cnt counts 0..REFRESH_DIV-1, then wraps to 0.
  - tick = (cnt == REFRESH_DIV-1).
  - On tick, idx advances by 1 and wraps from NUM_DIGITS-1 to 0.
- Outputs are registered. Each cycle they are computed from the pre-edge cnt, idx and snapshot, and appear after the edge (1-cycle latency).
- Dead time: when pre-edge cnt==0, the next output is an = all 1s and seg = 7'h7F, dp = 1. This gives one dark cycle at the start of every slot.
- Otherwise, an = ~(1 << idx) and scan_idx = idx.
- seg decode (active-low, a..g):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100.
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
  - HEX_MODE=1: A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
  - HEX_MODE=0: codes 10-15 give 1111111.
- Leading-zero blanking (LZ_BLANK=1):
  - Digit i is blanked when its nibble and all nibbles of higher index are 0.
  - Digit 0 is never LZ-blanked.
  - A blank_in bit does not count as a non-zero digit.
- Blanked digit (blank_in, LZ, or HEX_MODE=0 code 10-15): seg = 7'h7F. Its anode is still asserted so scan timing stays uniform.
- dp = ~dp_in[idx], except dp = 1 when blank_in[idx]=1. LZ blanking does not suppress dp.
- enable=0:
  - cnt and idx are forced to 0 at the next edge.
  - Next outputs: an = all 1s, seg = 7'h7F, dp = 1.
  - The snapshot still accepts update.
  - When enable returns to 1, scanning restarts at slot 0 with a dead cycle.
- rst mid-slot overrides everything, including update in the same cycle.
- NUM_DIGITS=1: idx stays at 0; the dead cycle still occurs every REFRESH_DIV cycles.

Test Plan:
Bench configuration for all scenarios unless stated: NUM_DIGITS=4, REFRESH_DIV=4, HEX_MODE=0, LZ_BLANK=1.
- Reset, then enable=1 with no update -> outputs are as follows; verify an sequence 1111,1111,1110,1110,1110,1111,1101... scan_idx follows 0,1,2,3,0.
  - Digit 0: seg=0000001.
  - Digits 1-3: LZ-blanked, seg=1111111.
  - an sequence per slot: dead cycle then an=1110, 1101, 1011, 0111.
- update with digits_in=16'h1205, dp_in=4'b0100 -> outputs are as follows; change digits_in without update -> display unchanged.
  - Digit 3 shows 1001111, digit 2 shows 0010010 with dp=0.
  - Digit 1 shows 0000001 (not LZ-blanked, since a higher digit is non-zero), digit 0 shows 0100100.
- update with digits_in=16'h00A3 (HEX_MODE=0) -> digit 1 blank, digit 0 = 0000110; same stimulus with HEX_MODE=1 -> digit 1 = 0001000.
- blank_in=4'b0001 with dp_in=4'b0001 and digits 0007 -> digit 0 seg=1111111, dp=1; other digits LZ-blanked; anodes still scan.
- enable dropped during slot 2 -> one cycle later an=1111, seg=7'h7F; re-enable -> dead cycle, then an=1110 (idx restarted at 0).
- rst asserted in the same cycle as update with nonzero data -> snapshot stays 0, outputs return to reset values next cycle.
